ps2_keycode_source: RTL and testbench

PS/2 keyboard front end producing the 8-bit HID-style `keycode` consumed by the frog movement logic. It deserializes PS/2 device-to-host frames and tracks make/break/extended prefixes. It translates set-2 scan codes for W/A/S/D, the arrows, Enter and Space into keycodes, and holds the code while the key is down. On release the output returns to 0x00, so every new press is seen downstream as a keycode change.

---
 rtl/ps2_keycode_source.sv | 192 +++++++++++++++++++
 tb/tb_ps2_keycode_source.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_source.sv
// PS/2 keyboard front end: deserializes set-2 frames, tracks F0/E0 prefixes and
// presents the currently held movement key as an 8-bit HID-style keycode.
module ps2_keycode_source #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       HardReset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  function automatic logic [7:0] xlate(input logic [7:0] sc, input logic ext);
    logic [7:0] r;
    r = 8'h00;
    if (ext) begin
      case (sc)
        8'h75:   r = 8'h1A;
        8'h6B:   r = 8'h04;
        8'h72:   r = 8'h16;
        8'h74:   r = 8'h07;
        default: r = 8'h00;
      endcase
    end else begin
      case (sc)
        8'h1D:   r = 8'h1A;
        8'h1C:   r = 8'h04;
        8'h1B:   r = 8'h16;
        8'h23:   r = 8'h07;
        8'h5A:   r = 8'h28;
        8'h29:   r = 8'h2C;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // Keyboard housekeeping bytes that must not disturb the prefix tracker.
  function automatic logic is_ignored(input logic [7:0] sc);
    return (sc == 8'hE1) || (sc == 8'hAA) || (sc == 8'hFA) ||
           (sc == 8'hEE) || (sc == 8'h00) || (sc == 8'hFF);
  endfunction

  logic              pclk_s1_q, pclk_s2_q, pclk_h_q;
  logic              pdat_s1_q, pdat_s2_q;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        keycode_q, keycode_d;
  logic              kc_chg_q;
  logic              key_valid_q;
  logic              frame_err_q;

  logic              fall;
  logic              byte_ok;
  logic              err;
  logic              do_make, do_brk, use_ext;
  logic [7:0]        xv;

  assign fall = pclk_h_q & ~pclk_s2_q;

  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    idle_d   = idle_q;
    byte_ok  = 1'b0;
    err      = 1'b0;
    if (fall) begin
      idle_d = '0;
      case (bitcnt_q)
        4'd0: if (!pdat_s2_q) bitcnt_d = 4'd1;
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d  = {pdat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end
        4'd9: begin
          parity_d = pdat_s2_q;
          bitcnt_d = 4'd10;
        end
        4'd10: begin
          bitcnt_d = 4'd0;
          if ((^{shift_q, parity_q}) && pdat_s2_q) byte_ok = 1'b1;
          else                                     err     = 1'b1;
        end
        default: bitcnt_d = 4'd0;
      endcase
    end else if (bitcnt_q != 4'd0) begin
      // An edge in the same cycle wins over the timeout (handled above).
      if (idle_q == IDLE_LIMIT) begin
        bitcnt_d = 4'd0;
        idle_d   = '0;
        err      = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    keycode_d = keycode_q;
    do_make   = 1'b0;
    do_brk    = 1'b0;
    use_ext   = 1'b0;
    xv        = 8'h00;
    if (byte_ok) begin
      case (state_q)
        ST_IDLE: begin
          if (shift_q == 8'hF0)      state_d = ST_BRK;
          else if (shift_q == 8'hE0) state_d = ST_EXT;
          else if (!is_ignored(shift_q)) do_make = 1'b1;
        end
        ST_BRK: begin
          do_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (shift_q == 8'hF0) begin
            state_d = ST_EXT_BRK;
          end else begin
            do_make = 1'b1;
            use_ext = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          do_brk  = 1'b1;
          use_ext = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    xv = xlate(shift_q, use_ext);
    if (do_make && (xv != 8'h00)) keycode_d = xv;
    if (do_brk && (xv != 8'h00) && (xv == keycode_q)) keycode_d = 8'h00;
  end

  always_ff @(posedge clk or posedge HardReset) begin
    if (HardReset) begin
      pclk_s1_q   <= 1'b1;
      pclk_s2_q   <= 1'b1;
      pclk_h_q    <= 1'b1;
      pdat_s1_q   <= 1'b1;
      pdat_s2_q   <= 1'b1;
      bitcnt_q    <= 4'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      idle_q      <= '0;
      state_q     <= ST_IDLE;
      keycode_q   <= 8'h00;
      kc_chg_q    <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      pclk_s1_q   <= ps2_clk;
      pclk_s2_q   <= pclk_s1_q;
      pclk_h_q    <= pclk_s2_q;
      pdat_s1_q   <= ps2_data;
      pdat_s2_q   <= pdat_s1_q;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      idle_q      <= idle_d;
      state_q     <= state_d;
      keycode_q   <= keycode_d;
      // key_valid trails the keycode register change by one cycle.
      kc_chg_q    <= (keycode_d != keycode_q);
      key_valid_q <= kc_chg_q;
      frame_err_q <= err;
    end
  end

  assign keycode   = keycode_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_source.sv
// Randomized and directed bench for ps2_keycode_source with a queue-based scoreboard.
module tb_ps2_keycode_source;

  localparam int TO   = 200;
  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       HardReset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_source #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .HardReset (HardReset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int err_exp  = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_kc  = 8'h00;
  bit         m_brk = 1'b0;
  bit         m_ext = 1'b0;
  logic [7:0] kc_prev = 8'h00;
  bit         pend = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int lookup(input bit ext, input logic [7:0] b);
    if (ext) begin
      case (b)
        8'h75: return 'h1A;  8'h6B: return 'h04;
        8'h72: return 'h16;  8'h74: return 'h07;
        default: return -1;
      endcase
    end
    case (b)
      8'h1D: return 'h1A;  8'h1C: return 'h04;  8'h1B: return 'h16;
      8'h23: return 'h07;  8'h5A: return 'h28;  8'h29: return 'h2C;
      default: return -1;
    endcase
  endfunction

  task automatic model_set(input logic [7:0] n);
    if (n != m_kc) begin
      m_kc = n;
      exp_q.push_back(n);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int v;
    if (!m_brk && !m_ext && (b inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF})) return;
    if (!m_brk && b == 8'hF0) begin m_brk = 1'b1; return; end
    if (!m_brk && !m_ext && b == 8'hE0) begin m_ext = 1'b1; return; end
    v = lookup(m_ext, b);
    if (v >= 0) begin
      if (m_brk) begin
        if (8'(v) == m_kc) model_set(8'h00);
      end else begin
        model_set(8'(v));
      end
    end
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  always @(negedge clk) begin
    if (HardReset) begin
      kc_prev = 8'h00;
      pend    = 1'b0;
    end else begin
      if (key_valid || pend) begin
        check("key_valid_timing", {31'd0, key_valid}, {31'd0, pend});
        if (key_valid) begin
          if (exp_q.size() == 0) check("key_valid_unexpected", 32'd1, 32'd0);
          else                   check("keycode_on_valid", {24'd0, keycode}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_err) err_seen++;
      pend    = (keycode != kc_prev);
      kc_prev = keycode;
    end
  end

  task automatic send_frame(input logic [7:0] b, input int nbits, input bit bad_par,
                            input bit bad_stop, input int lat_exp);
    logic [10:0] fr;
    int n;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      #(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && lat_exp >= 0) begin
        n = 0;
        for (int k = 1; k <= 15; k++) begin
          @(posedge clk); #1;
          if (n == 0 && keycode == 8'(lat_exp)) n = k;
        end
        check("stop_to_keycode_latency", {31'd0, (n >= 3 && n <= 4)}, 32'd1);
      end
      #(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #3;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 11, 1'b0, 1'b0, -1);
    idle(50);
  endtask

  task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    err_exp++;
    send_frame(b, 11, bad_par, bad_stop, -1);
    idle(50);
  endtask

  task automatic checkpoint(input string nm);
    check({nm, "_keycode"}, {24'd0, keycode}, {24'd0, m_kc});
    check({nm, "_frame_err_count"}, err_seen, err_exp);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    HardReset = 1'b1;
    m_kc = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    HardReset = 1'b0;
    idle(2);
  endtask

  logic [7:0] keys[10] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h5A, 8'h29, 8'h75, 8'h6B, 8'h72, 8'h74};
  logic [7:0] ign[6]   = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF};

  initial begin
    int viol;
    int r;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #2 HardReset = 1'b0;
    idle(1);

    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (keycode != 8'h00 || key_valid || frame_err) viol++;
    end
    check("reset_idle_quiet", viol, 0);
    idle(1);

    // First press with latency measurement.
    model_byte(8'h1C);
    send_frame(8'h1C, 11, 1'b0, 1'b0, 8'h04);
    idle(50);
    check("make_1C", {24'd0, keycode}, 32'h04);
    send_byte(8'h1C);
    check("typematic_1C", {24'd0, keycode}, 32'h04);
    send_byte(8'hF0); send_byte(8'h1C);
    check("break_1C", {24'd0, keycode}, 32'h00);

    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h23);
    check("break_other_key", {24'd0, keycode}, 32'h04);
    send_byte(8'hE0); send_byte(8'h75);
    check("make_ext_75", {24'd0, keycode}, 32'h1A);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("break_ext_75", {24'd0, keycode}, 32'h00);
    checkpoint("prefix_seq");

    send_byte(8'h29);
    send_bad(8'h1D, 1'b1, 1'b0);
    check("bad_parity_keycode", {24'd0, keycode}, 32'h2C);
    send_bad(8'h1D, 1'b0, 1'b1);
    check("bad_stop_keycode", {24'd0, keycode}, 32'h2C);
    checkpoint("frame_errors");

    err_exp++;
    send_frame(8'h55, 5, 1'b0, 1'b0, -1);
    idle(TO + 50);
    checkpoint("timeout");
    send_byte(8'h1B);
    check("after_timeout_1B", {24'd0, keycode}, 32'h16);

    send_frame(8'h23, 5, 1'b0, 1'b0, -1);
    do_reset();
    check("reset_mid_frame_keycode", {24'd0, keycode}, 32'h00);
    send_byte(8'h1C);
    check("after_reset_1C", {24'd0, keycode}, 32'h04);
    checkpoint("after_reset");

    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      b = keys[$urandom_range(0, 9)];
      else if (r == 5) b = 8'hF0;
      else if (r == 6) b = 8'hE0;
      else if (r == 7) b = 8'($urandom);
      else if (r == 8) b = ign[$urandom_range(0, 5)];
      else             b = 8'($urandom);
      if (r == 9) send_bad(b, $urandom_range(0, 1) == 1, 1'b1);
      else        send_byte(b);
      check("random_keycode", {24'd0, keycode}, {24'd0, m_kc});
    end
    checkpoint("random_end");
    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
